// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - register-file read port and debug byte stream bundle
// The master side is the dump reader; the slave side is the register file plus the UART sink.
interface regfile_dump_reader_if;
  logic        rf_req;
  logic        rf_gnt;
  logic [4:0]  rf_read_id;
  logic [31:0] rf_read_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output rf_req, rf_read_id, out_data, out_valid,
    input  rf_gnt, rf_read_data, out_ready
  );

  modport slave (
    input  rf_req, rf_read_id, out_data, out_valid,
    output rf_gnt, rf_read_data, out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - dumps x0..x(NUM_REGS-1) as a header/data/XOR-checksum byte frame
// Register reads borrow the core's read port via req/gnt; bytes go out little-endian per register.
module regfile_dump_reader #(
  parameter int          NUM_REGS    = 32,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  regfile_dump_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    FETCH,
    SEND,
    CSUM
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [4:0]  index_q, index_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    csum_d  = csum_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the finished frame and is dropped.
        if (start && !done_q) begin
          index_d = 5'd0;
          csum_d  = 8'd0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (bus.out_ready) state_d = FETCH;
      end
      FETCH: begin
        if (bus.rf_gnt) begin
          shift_d = bus.rf_read_data;
          cnt_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          csum_d  = csum_q ^ shift_q[7:0];
          shift_d = {8'h00, shift_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (index_q == LAST_IDX) begin
              state_d = CSUM;
            end else begin
              index_d = index_q + 5'd1;
              state_d = FETCH;
            end
          end
        end
      end
      CSUM: begin
        if (bus.out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= 5'd0;
      csum_q  <= 8'd0;
      shift_q <= 32'd0;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      csum_q  <= csum_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode only registered state, so ready/gnt never reach an output combinationally.
  always_comb begin
    bus.out_data = 8'h00;
    case (state_q)
      HEADER:  bus.out_data = HEADER_BYTE;
      SEND:    bus.out_data = shift_q[7:0];
      CSUM:    bus.out_data = csum_q;
      default: bus.out_data = 8'h00;
    endcase
  end

  assign bus.out_valid  = (state_q == HEADER) || (state_q == SEND) || (state_q == CSUM);
  assign bus.rf_req     = (state_q == FETCH);
  assign bus.rf_read_id = index_q;
  assign done           = done_q;
  // The done cycle still counts as part of the dump; busy drops the cycle after.
  assign busy           = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic [31:0] rf [32];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int hold_err = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  regfile_dump_reader_if bus();

  regfile_dump_reader #(.NUM_REGS(N), .HEADER_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  assign bus.rf_read_data = rf[bus.rf_read_id];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    if (!rst && done) done_cnt++;
    if (!rst && prev_v && !prev_r && (!bus.out_valid || bus.out_data !== prev_d)) hold_err++;
    prev_v = bus.out_valid && !rst;
    prev_r = bus.out_ready;
    prev_d = bus.out_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp();
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = rf[i][8*k +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic cmp_frame(input string tag);
    int nerr;
    int first;
    nerr = 0;
    first = -1;
    build_exp();
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        nerr++;
        if (first < 0) first = i;
      end
    end
    chk({tag, "_bytes_bad"}, nerr, 0);
    if (first >= 0) chk({tag, "_first_bad_byte"}, got_q[first], exp_q[first]);
  endtask

  task automatic pulse_start(output int t);
    @(posedge clk); #1;
    start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit stall, input int t, output int dcyc);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(posedge clk); #1;
      if (stall) bus.out_ready = ($urandom_range(0, 99) >= 40);
      k++;
    end
    bus.out_ready = 1'b1;
    dcyc = cyc - t;
    if (!done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rf_req"}, bus.rf_req, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_data"}, bus.out_data, 8'h00);
    chk({tag, "_rf_read_id"}, bus.rf_read_id, 5'd0);
  endtask

  initial begin
    int t, dcyc, d0, k, badc, q0;
    bus.rf_gnt = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'h01010101 * i;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Frame 1: ramp data, no stalls, exact latency
    got_q.delete();
    d0 = done_cnt;
    pulse_start(t);
    chk("t1_header_valid", bus.out_valid, 1'b1);
    chk("t1_header_byte", bus.out_data, 8'hA5);
    wait_done("t1", 1'b0, t, dcyc);
    chk("t1_done_latency", dcyc, 163);
    @(posedge clk); #1;
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_done_pulses", done_cnt - d0, 1);
    cmp_frame("t1");
    if (got_q.size() == 130) chk("t1_csum", got_q[129], 8'h00);

    // Frame 2: only x5 nonzero
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[5] = 32'hDEADBEEF;
    got_q.delete();
    pulse_start(t);
    wait_done("t2", 1'b0, t, dcyc);
    cmp_frame("t2");
    if (got_q.size() == 130) begin
      chk("t2_x5_bytes", {got_q[24], got_q[23], got_q[22], got_q[21]}, 32'hDEADBEEF);
      chk("t2_x5_b0", got_q[21], 8'hEF);
      chk("t2_csum", got_q[129], 8'h22);
    end

    // Frame 3: grant withheld at x7 while its value changes
    rf[7] = 32'h11111111;
    got_q.delete();
    pulse_start(t);
    k = 0;
    while (!(bus.rf_req && bus.rf_read_id == 5'd7) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t3_reach_x7", bus.rf_read_id, 5'd7);
    bus.rf_gnt = 1'b0;
    q0 = got_q.size();
    badc = 0;
    for (int j = 0; j < 10; j++) begin
      if (!bus.rf_req || bus.rf_read_id != 5'd7 || bus.out_valid) badc++;
      if (j == 8) rf[7] = 32'hCAFEF00D;
      @(posedge clk); #1;
    end
    chk("t3_stall_cycles_bad", badc, 0);
    chk("t3_no_bytes_in_stall", got_q.size(), q0);
    bus.rf_gnt = 1'b1;
    wait_done("t3", 1'b0, t, dcyc);
    cmp_frame("t3");
    if (got_q.size() == 130) begin
      chk("t3_x7_bytes", {got_q[32], got_q[31], got_q[30], got_q[29]}, 32'hCAFEF00D);
      chk("t3_csum", got_q[129], 8'hEB);
    end

    // Frame 4: ~40% out_ready stall, ramp data
    for (int i = 0; i < 32; i++) rf[i] = 32'h01010101 * i;
    got_q.delete();
    hold_err = 0;
    pulse_start(t);
    wait_done("t4", 1'b1, t, dcyc);
    @(posedge clk); #1;
    chk("t4_hold_violations", hold_err, 0);
    cmp_frame("t4");

    // Reset while x12 byte 2 is on the stream
    got_q.delete();
    d0 = done_cnt;
    pulse_start(t);
    k = 0;
    while (!(got_q.size() == 51 && bus.out_valid) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t5_at_x12_b2", got_q.size(), 51);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("t5_after_rst");
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_no_extra_bytes", got_q.size(), 51);
    got_q.delete();
    pulse_start(t);
    wait_done("t5b", 1'b0, t, dcyc);
    chk("t5b_done_latency", dcyc, 163);
    @(posedge clk); #1;
    cmp_frame("t5b");

    // start while busy and in the done cycle
    got_q.delete();
    d0 = done_cnt;
    pulse_start(t);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_busy_mid", busy, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6", 1'b0, t, dcyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_busy_after_done", busy, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_idle", busy, 1'b0);
    chk("t6_done_pulses", done_cnt - d0, 1);
    chk("t6_one_frame", got_q.size(), 130);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
